// File: rtl/clasificador_entrada_pkg.sv
// Shared word layout and constants for the ingress classifier and the class arbiter.
// The arbiter decodes the same class/destination bit positions.
package clasificador_entrada_pkg;

  localparam int WORD_SIZE   = 12;
  localparam int CNT_W       = 8;
  localparam int NUM_CLASSES = 4;

  localparam int CLASS_MSB = WORD_SIZE - 1;
  localparam int CLASS_LSB = WORD_SIZE - 2;
  localparam int DEST_MSB  = WORD_SIZE - 3;
  localparam int DEST_LSB  = WORD_SIZE - 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/clasificador_entrada_skid_buffer2.sv
// Two-entry in-order skid buffer; entry0 is always the head.
// state     | meaning
// OCC_EMPTY | nothing buffered, head invalid
// OCC_ONE   | entry0 holds the head
// OCC_FULL  | entry0 head, entry1 next; upstream stalled
module skid_buffer2
  import clasificador_entrada_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  input  logic             pop
);

  occ_t             state, state_next;
  logic [WIDTH-1:0] entry0, entry1;
  logic             accept;
  logic             load0, load1, shift;

  assign in_ready   = (state != OCC_FULL);
  assign head_valid = (state != OCC_EMPTY);
  assign head       = entry0;
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= OCC_EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      state <= state_next;
      if (load0)
        entry0 <= in_data;
      else if (shift)
        entry0 <= entry1;
      if (load1)
        entry1 <= in_data;
    end
  end

  always_comb begin
    state_next = state;
    load0      = 1'b0;
    load1      = 1'b0;
    shift      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          load0      = 1'b1;
          state_next = OCC_ONE;
        end
      end
      OCC_ONE: begin
        // Accept with pop replaces the head in place, keeping occupancy.
        case ({accept, pop})
          2'b11: load0 = 1'b1;
          2'b10: begin
            load1      = 1'b1;
            state_next = OCC_FULL;
          end
          2'b01: state_next = OCC_EMPTY;
          default: state_next = OCC_ONE;
        endcase
      end
      OCC_FULL: begin
        if (pop) begin
          shift      = 1'b1;
          state_next = OCC_ONE;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/clasificador_entrada.sv
// Ingress writer: steers buffered words into four class FIFOs by class bits,
// stalling in order on the target FIFO's almost_full, with per-class push counters.
module clasificador_entrada
  import clasificador_entrada_pkg::*;
#(
  parameter int WORD_SIZE = clasificador_entrada_pkg::WORD_SIZE,
  parameter int CNT_W     = clasificador_entrada_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WORD_SIZE-1:0]   in_data,
  output logic                   in_ready,
  input  logic [NUM_CLASSES-1:0] fifos_almost_full,
  output logic [NUM_CLASSES-1:0] fifos_push,
  output logic [WORD_SIZE-1:0]   fifo_data_out,
  input  logic [1:0]             cnt_sel,
  output logic [CNT_W-1:0]       cnt_out
);

  logic [WORD_SIZE-1:0] head;
  logic                 head_valid;
  logic [1:0]           head_class;
  logic                 issue;
  logic [CNT_W-1:0]     cnt [NUM_CLASSES];

  skid_buffer2 #(
    .WIDTH (WORD_SIZE)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .head       (head),
    .head_valid (head_valid),
    .pop        (issue)
  );

  assign head_class = head[CLASS_MSB:CLASS_LSB];
  // Head-of-line blocking is deliberate: a stalled head holds back every later class.
  assign issue      = head_valid & ~fifos_almost_full[head_class];
  assign cnt_out    = cnt[cnt_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifos_push    <= '0;
      fifo_data_out <= '0;
      for (int i = 0; i < NUM_CLASSES; i++)
        cnt[i] <= '0;
    end else begin
      if (issue) begin
        fifos_push      <= (NUM_CLASSES)'(1) << head_class;
        fifo_data_out   <= head;
        cnt[head_class] <= cnt[head_class] + 1'b1;
      end else begin
        fifos_push <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clasificador_entrada.sv
// Directed self-checking bench for clasificador_entrada: vector table plus
// hand-written stall, backpressure, wrap and async-reset sequences.
module tb_clasificador_entrada;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic [3:0]  fifos_almost_full;
  logic [3:0]  fifos_push;
  logic [11:0] fifo_data_out;
  logic [1:0]  cnt_sel;
  logic [7:0]  cnt_out;

  int tests_run = 0;
  int tests_failed = 0;

  clasificador_entrada dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .fifos_almost_full (fifos_almost_full),
    .fifos_push        (fifos_push),
    .fifo_data_out     (fifo_data_out),
    .cnt_sel           (cnt_sel),
    .cnt_out           (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [11:0] d;
    logic [3:0]  af;
    logic [1:0]  sel;
    logic        e_ready;
    logic [3:0]  e_push;
    logic [11:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [11:0] d, input logic [3:0] af, input logic [1:0] sel,
                     input logic er, input logic [3:0] ep, input logic [11:0] ed, input logic [7:0] ec);
    vec_t x;
    x.v = v; x.d = d; x.af = af; x.sel = sel;
    x.e_ready = er; x.e_push = ep; x.e_data = ed; x.e_cnt = ec;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    fifos_almost_full = '0;
    cnt_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pushes;
    int sent;
    int out_idx;
    logic acc;

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    fifos_almost_full = '0;
    cnt_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_push", fifos_push, 4'b0000);
    check("rst_data", fifo_data_out, 12'h000);
    check("rst_ready", in_ready, 1'b1);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      check("rst_cnt", cnt_out, 8'd0);
    end
    cnt_sel = 2'd0;

    // Single word latency
    in_valid = 1'b1;
    in_data = 12'h2A5;
    @(negedge clk);
    check("single_no_push_yet", fifos_push, 4'b0000);
    check("single_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_push", fifos_push, 4'b0001);
    check("single_data", fifo_data_out, 12'h2A5);
    check("single_cnt0", cnt_out, 8'd1);
    @(negedge clk);
    check("single_push_drop", fifos_push, 4'b0000);
    check("single_data_hold", fifo_data_out, 12'h2A5);

    // Table: 8-word class-cycling stream, then counter readout
    do_reset();
    add(1, 12'h0A0, 4'h0, 2'd0, 1, 4'b0000, 12'h000, 8'd0);
    add(1, 12'h4A1, 4'h0, 2'd0, 1, 4'b0001, 12'h0A0, 8'd1);
    add(1, 12'h8A2, 4'h0, 2'd0, 1, 4'b0010, 12'h4A1, 8'd1);
    add(1, 12'hCA3, 4'h0, 2'd0, 1, 4'b0100, 12'h8A2, 8'd1);
    add(1, 12'h1B4, 4'h0, 2'd0, 1, 4'b1000, 12'hCA3, 8'd1);
    add(1, 12'h5B5, 4'h0, 2'd0, 1, 4'b0001, 12'h1B4, 8'd2);
    add(1, 12'h9B6, 4'h0, 2'd0, 1, 4'b0010, 12'h5B5, 8'd2);
    add(1, 12'hDB7, 4'h0, 2'd0, 1, 4'b0100, 12'h9B6, 8'd2);
    add(0, 12'hFFF, 4'h0, 2'd0, 1, 4'b1000, 12'hDB7, 8'd2);
    add(0, 12'hFFF, 4'h0, 2'd0, 1, 4'b0000, 12'hDB7, 8'd2);
    add(0, 12'h000, 4'h0, 2'd1, 1, 4'b0000, 12'hDB7, 8'd2);
    add(0, 12'h000, 4'h0, 2'd2, 1, 4'b0000, 12'hDB7, 8'd2);
    add(0, 12'h000, 4'h0, 2'd3, 1, 4'b0000, 12'hDB7, 8'd2);
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v;
      in_data = vecs[i].d;
      fifos_almost_full = vecs[i].af;
      cnt_sel = vecs[i].sel;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_push", i), fifos_push, vecs[i].e_push);
      check($sformatf("vec%0d_data", i), fifo_data_out, vecs[i].e_data);
      check($sformatf("vec%0d_cnt", i), cnt_out, vecs[i].e_cnt);
    end

    // Head-of-line block: class 2 stalled holds back class 0
    do_reset();
    fifos_almost_full = 4'b0100;
    in_valid = 1'b1;
    in_data = 12'h8C2;
    @(negedge clk);
    in_data = 12'h0C3;
    @(negedge clk);
    in_valid = 1'b0;
    check("hol_ready_full", in_ready, 1'b0);
    check("hol_no_push", fifos_push, 4'b0000);
    @(negedge clk);
    check("hol_still_blocked", fifos_push, 4'b0000);
    check("hol_ready_still_low", in_ready, 1'b0);
    fifos_almost_full = 4'b0000;
    @(negedge clk);
    check("hol_push_c2", fifos_push, 4'b0100);
    check("hol_data_c2", fifo_data_out, 12'h8C2);
    check("hol_ready_back", in_ready, 1'b1);
    @(negedge clk);
    check("hol_push_c0", fifos_push, 4'b0001);
    check("hol_data_c0", fifo_data_out, 12'h0C3);
    @(negedge clk);
    check("hol_idle", fifos_push, 4'b0000);

    // Backpressure with in_valid held high; scoreboard on order and count
    do_reset();
    fifos_almost_full = 4'b0010;
    sent = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (fifos_push != 4'b0000) begin
        check("bp_push_onehot", fifos_push, 4'b0010);
        check("bp_order", fifo_data_out, 12'h400 + 12'(out_idx));
        out_idx++;
      end
      if (cyc == 6) begin
        check("bp_accepted_two", sent, 2);
        check("bp_ready_low", in_ready, 1'b0);
        fifos_almost_full = 4'b0000;
      end
      in_valid = (sent < 6);
      in_data = (sent < 6) ? 12'h400 + 12'(sent) : 12'hxxx;
      #1;
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_sent", sent, 6);
    check("bp_received", out_idx, 6);

    // Counter wrap: 256 class-3 pushes
    do_reset();
    pushes = 0;
    cnt_sel = 2'd3;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_data = 12'hC00 | 12'(k & 255);
      @(negedge clk);
      if (fifos_push != 4'b0000) pushes++;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fifos_push != 4'b0000) pushes++;
    end
    check("wrap_push_count", pushes, 256);
    check("wrap_cnt3", cnt_out, 8'd0);
    for (int s = 0; s < 3; s++) begin
      cnt_sel = 2'(s);
      #1;
      check($sformatf("wrap_cnt%0d", s), cnt_out, 8'd0);
    end

    // Asynchronous reset mid-cycle with a push active and a word buffered
    do_reset();
    cnt_sel = 2'd1;
    fifos_almost_full = 4'b0010;
    in_valid = 1'b1;
    in_data = 12'h411;
    @(negedge clk);
    in_data = 12'h422;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre_full", in_ready, 1'b0);
    fifos_almost_full = 4'b0000;
    @(posedge clk);
    #2;
    check("arst_pre_push", fifos_push, 4'b0010);
    reset = 1'b1;
    #1;
    check("arst_push_cleared", fifos_push, 4'b0000);
    check("arst_ready", in_ready, 1'b1);
    check("arst_cnt1", cnt_out, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pushes = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifos_push != 4'b0000) pushes++;
    end
    check("arst_flushed", pushes, 0);
    check("arst_ready_after", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
